// File: rtl/cache_ctrl_pkg.sv
// Shared widths, address layout and controller state encoding for the cache controller.
package cache_ctrl_pkg;

    localparam int unsigned IDX_W   = 8;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned BSEL_W  = 2;
    localparam int unsigned LINES   = 1 << IDX_W;
    localparam int unsigned DRAM_AW = IDX_W + BSEL_W;
    localparam int unsigned MEM_AW  = TAG_W + IDX_W + BSEL_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic [BSEL_W-1:0] bytesel;
    } address_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_MEMWR,
        ST_RESP
    } cache_ctrl_state_t;

    // Main-memory byte address for a tag/index/byte triple.
    function automatic address_t make_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [IDX_W-1:0]  index,
        input logic [BSEL_W-1:0] bytesel
    );
        address_t a;
        a.tag     = tag;
        a.index   = index;
        a.bytesel = bytesel;
        return a;
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid store: one tag and valid bit per line, combinational lookup, single write port.
module cache_tag_store
    import cache_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tagmem [LINES];

    // Valid bits are the only state that must be cleared; stale tags are masked by them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tagmem[wr_index] <= wr_tag;
        end
    end

    assign hit_c = valid[lookup_index] && (tagmem[lookup_index] == lookup_tag);

endmodule

// File: rtl/cache_ctrl.sv
// Processor-to-cache sequencing controller: direct-mapped, write-through, no-write-allocate.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned BSEL_W = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           rw,
    input  logic [IDX_W-1:0]               index,
    input  logic [TAG_W-1:0]               tag,
    input  logic [BSEL_W-1:0]              bytesel,
    input  logic [7:0]                     wdata,
    output logic [7:0]                     rdata,
    output logic                           stall,
    output logic                           hit,
    output logic                           miss,
    output logic                           done,
    output logic [IDX_W+BSEL_W-1:0]        dram_addr,
    output logic                           dram_we,
    output logic [7:0]                     dram_wdata,
    input  logic [7:0]                     dram_rdata,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [TAG_W+IDX_W+BSEL_W-1:0]  mem_addr,
    output logic [7:0]                     mem_wdata,
    input  logic                           mem_ack,
    input  logic [7:0]                     mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]                    hit_count,
    output logic [15:0]                    miss_count
`endif
);

    import cache_ctrl_pkg::*;

    cache_ctrl_state_t   state, nxt_state;
    logic                cmd_rw, nxt_rw;
    logic [IDX_W-1:0]    cmd_index, nxt_index;
    logic [TAG_W-1:0]    cmd_tag, nxt_tag;
    logic [BSEL_W-1:0]   cmd_bsel, nxt_bsel;
    logic [7:0]          cmd_wdata, nxt_wdata;
    logic [BSEL_W-1:0]   k, nxt_k;
    logic [7:0]          rdata_q, nxt_rdata;
    logic                from_ram, nxt_from_ram;
    logic                nxt_stall, nxt_hit, nxt_miss, nxt_done;
    logic                nxt_dram_we;
    logic [IDX_W+BSEL_W-1:0]       nxt_dram_addr;
    logic [7:0]                    nxt_dram_wdata;
    logic                          nxt_mem_req, nxt_mem_we;
    logic [TAG_W+IDX_W+BSEL_W-1:0] nxt_mem_addr;
    logic [7:0]                    nxt_mem_wdata;
    logic                          lookup_hit_c;
    logic                          tag_we_c;

    // Lookup is done on the raw command at acceptance so hit/miss can be registered for LOOKUP.
    cache_tag_store u_tag_store (
        .clock        (clock),
        .reset        (reset),
        .lookup_index (index),
        .lookup_tag   (tag),
        .hit_c        (lookup_hit_c),
        .wr_en        (tag_we_c),
        .wr_index     (cmd_index),
        .wr_tag       (cmd_tag)
    );

    // Hit data is taken straight from the RAM's registered output to keep read-hit latency at two.
    assign rdata = (state == ST_RESP && from_ram) ? dram_rdata : rdata_q;

    always_comb begin
        nxt_state      = state;
        nxt_rw         = cmd_rw;
        nxt_index      = cmd_index;
        nxt_tag        = cmd_tag;
        nxt_bsel       = cmd_bsel;
        nxt_wdata      = cmd_wdata;
        nxt_k          = k;
        nxt_rdata      = rdata_q;
        nxt_from_ram   = from_ram;
        nxt_hit        = 1'b0;
        nxt_miss       = 1'b0;
        nxt_done       = 1'b0;
        nxt_dram_we    = 1'b0;
        nxt_dram_addr  = dram_addr;
        nxt_dram_wdata = dram_wdata;
        nxt_mem_req    = mem_req;
        nxt_mem_we     = mem_we;
        nxt_mem_addr   = mem_addr;
        nxt_mem_wdata  = mem_wdata;
        tag_we_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    nxt_rw        = rw;
                    nxt_index     = index;
                    nxt_tag       = tag;
                    nxt_bsel      = bytesel;
                    nxt_wdata     = wdata;
                    nxt_hit       = lookup_hit_c;
                    nxt_miss      = !lookup_hit_c;
                    nxt_from_ram  = 1'b0;
                    nxt_dram_addr = {index, bytesel};
                    nxt_state     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cmd_rw && hit) begin
                    nxt_from_ram = 1'b1;
                    nxt_done     = 1'b1;
                    nxt_state    = ST_RESP;
                end else if (cmd_rw) begin
                    nxt_k        = '0;
                    nxt_mem_req  = 1'b1;
                    nxt_mem_we   = 1'b0;
                    nxt_mem_addr = make_addr(cmd_tag, cmd_index, '0);
                    nxt_state    = ST_FILL;
                end else begin
                    if (hit) begin
                        nxt_dram_we    = 1'b1;
                        nxt_dram_addr  = {cmd_index, cmd_bsel};
                        nxt_dram_wdata = cmd_wdata;
                    end
                    nxt_mem_req   = 1'b1;
                    nxt_mem_we    = 1'b1;
                    nxt_mem_addr  = make_addr(cmd_tag, cmd_index, cmd_bsel);
                    nxt_mem_wdata = cmd_wdata;
                    nxt_state     = ST_MEMWR;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    nxt_dram_we    = 1'b1;
                    nxt_dram_addr  = {cmd_index, k};
                    nxt_dram_wdata = mem_rdata;
                    if (k == cmd_bsel) begin
                        nxt_rdata = mem_rdata;
                    end
                    if (k == '1) begin
                        tag_we_c    = 1'b1;
                        nxt_mem_req = 1'b0;
                        nxt_done    = 1'b1;
                        nxt_state   = ST_RESP;
                    end else begin
                        nxt_k        = k + 1'b1;
                        nxt_mem_addr = make_addr(cmd_tag, cmd_index, k + 1'b1);
                    end
                end
            end
            ST_MEMWR: begin
                if (mem_ack) begin
                    nxt_mem_req = 1'b0;
                    nxt_mem_we  = 1'b0;
                    nxt_done    = 1'b1;
                    nxt_state   = ST_RESP;
                end
            end
            ST_RESP: begin
                nxt_from_ram = 1'b0;
                nxt_state    = ST_IDLE;
            end
            default: begin
                nxt_mem_req = 1'b0;
                nxt_state   = ST_IDLE;
            end
        endcase

        nxt_stall = (nxt_state != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cmd_rw     <= 1'b0;
            cmd_index  <= '0;
            cmd_tag    <= '0;
            cmd_bsel   <= '0;
            cmd_wdata  <= '0;
            k          <= '0;
            rdata_q    <= '0;
            from_ram   <= 1'b0;
            stall      <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            done       <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= nxt_state;
            cmd_rw     <= nxt_rw;
            cmd_index  <= nxt_index;
            cmd_tag    <= nxt_tag;
            cmd_bsel   <= nxt_bsel;
            cmd_wdata  <= nxt_wdata;
            k          <= nxt_k;
            rdata_q    <= nxt_rdata;
            from_ram   <= nxt_from_ram;
            stall      <= nxt_stall;
            hit        <= nxt_hit;
            miss       <= nxt_miss;
            done       <= nxt_done;
            dram_we    <= nxt_dram_we;
            dram_addr  <= nxt_dram_addr;
            dram_wdata <= nxt_dram_wdata;
            mem_req    <= nxt_mem_req;
            mem_we     <= nxt_mem_we;
            mem_addr   <= nxt_mem_addr;
            mem_wdata  <= nxt_mem_wdata;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // Saturating counters of lookup outcomes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized commands against a cache/memory model.
module tb_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, rw = 1'b0;
    logic [7:0]  index = '0;
    logic [5:0]  tag = '0;
    logic [1:0]  bytesel = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        stall, hit, miss, done;
    logic [9:0]  dram_addr;
    logic        dram_we;
    logic [7:0]  dram_wdata;
    logic [7:0]  dram_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clock = ~clock;

    cache_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .rw         (rw),
        .index      (index),
        .tag        (tag),
        .bytesel    (bytesel),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .hit        (hit),
        .miss       (miss),
        .done       (done),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // Data RAM with one cycle of read latency.
    logic [7:0] dram [1024];
    always @(posedge clock) begin
        if (dram_we) dram[dram_addr] <= dram_wdata;
        dram_rdata <= dram[dram_addr];
    end

    // Main memory and the reference copy the model predicts from.
    logic [7:0]  tb_mem  [65536];
    logic [7:0]  ref_mem [65536];
    bit          ref_valid [256];
    logic [5:0]  ref_tag [256];
    int          ack_mode = 0;
    int          beats = 0, req_cycles = 0;
    logic [15:0] fill_q [$];
    logic [15:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;
    int          total = 0, bad = 0;
    int          hit_n = 0, miss_n = 0;

    always @(negedge clock) begin
        mem_ack   = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        mem_rdata = tb_mem[mem_addr];
    end

    always @(posedge clock) begin
        if (reset && mem_req) begin
            req_cycles++;
            if (mem_ack) begin
                beats++;
                if (mem_we) begin
                    tb_mem[mem_addr] = mem_wdata;
                    last_waddr = mem_addr;
                    last_wdata = mem_wdata;
                end else begin
                    fill_q.push_back(mem_addr);
                end
            end
        end
    end

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Issue one command, watch it to completion and compare against the model.
    task automatic do_cmd(input bit r, input logic [7:0] idx, input logic [5:0] tg,
                          input logic [1:0] bs, input logic [7:0] wd, input bit chk_lat,
                          output logic [7:0] rd);
        logic [15:0] key;
        bit          exp_hit;
        logic [7:0]  exp_rd;
        int          hc, mc, cyc;
        bit          fin;
        key     = {tg, idx, bs};
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_rd  = ref_mem[key];
        rd      = '0;
        @(negedge clock);
        chk("idle_stall", 32'(stall), 0);
        beats = 0; req_cycles = 0; fill_q.delete();
        req = 1'b1; rw = r; index = idx; tag = tg; bytesel = bs; wdata = wd;
        hc = 0; mc = 0; cyc = 0; fin = 0;
        while (!fin && cyc < 200) begin
            @(negedge clock);
            cyc++;
            rw = 1'($urandom); index = 8'($urandom); tag = 6'($urandom);
            bytesel = 2'($urandom); wdata = 8'($urandom);
            if (hit) hc++;
            if (miss) mc++;
            if (done) begin
                fin = 1;
                rd  = rdata;
                req = 1'b0;
            end else begin
                req = 1'($urandom_range(0, 1));
            end
        end
        req = 1'b0;
        if (!fin) chk($sformatf("timeout_%h", key), 0, 1);
        chk($sformatf("hit_%h", key), 32'(hc), 32'(exp_hit));
        chk($sformatf("miss_%h", key), 32'(mc), 32'(!exp_hit));
        if (r) chk($sformatf("rdata_%h", key), 32'(rd), 32'(exp_rd));
        chk($sformatf("beats_%h", key), 32'(beats), r ? (exp_hit ? 0 : 4) : 1);
        if (r && exp_hit) chk($sformatf("no_mem_req_%h", key), 32'(req_cycles), 0);
        if (r && !exp_hit && fill_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("fill_addr%0d_%h", i, key), 32'(fill_q[i]), 32'({tg, idx, 2'(i)}));
        end
        if (!r) begin
            chk($sformatf("mem_waddr_%h", key), 32'(last_waddr), 32'(key));
            chk($sformatf("mem_wdata_%h", key), 32'(last_wdata), 32'(wd));
        end
        if (chk_lat) chk($sformatf("latency_%h", key), 32'(cyc), r ? (exp_hit ? 2 : 6) : 3);
        @(negedge clock);
        chk("done_single", 32'(done), 0);
        chk("stall_after", 32'(stall), 0);
        if (r && !exp_hit) begin
            ref_valid[idx] = 1;
            ref_tag[idx]   = tg;
        end
        if (!r) ref_mem[key] = wd;
        if (exp_hit) hit_n++; else miss_n++;
    endtask

    initial begin
        logic [7:0] rd;
        bit         reached;
        for (int a = 0; a < 65536; a++) begin
            tb_mem[a]  = init_byte(a);
            ref_mem[a] = tb_mem[a];
        end
        for (int j = 0; j < 4; j++) begin
            tb_mem[16'h0414 + j]  = 8'hA0 + 8'(j);
            ref_mem[16'h0414 + j] = 8'hA0 + 8'(j);
        end
        for (int i = 0; i < 256; i++) ref_valid[i] = 0;

        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ctrl", 32'({stall, hit, miss, done, dram_we, mem_req, mem_we}), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_mem", 32'({mem_addr, mem_wdata}), 0);
        chk("rst_dram", 32'({dram_addr, dram_wdata}), 0);
        reset = 1'b1;

        // Cold read miss, fill beats A0..A3, then a hit on the same byte.
        do_cmd(1, 8'h05, 6'h01, 2'd2, 8'h00, 1, rd);
        chk("tp_fill_rdata", 32'(rd), 32'h A2);
        do_cmd(1, 8'h05, 6'h01, 2'd2, 8'h00, 1, rd);
        chk("tp_hit_rdata", 32'(rd), 32'h A2);

        // Write hit updates RAM and memory; read back.
        do_cmd(0, 8'h05, 6'h01, 2'd0, 8'h5C, 1, rd);
        do_cmd(1, 8'h05, 6'h01, 2'd0, 8'h00, 1, rd);
        chk("tp_wr_readback", 32'(rd), 32'h5C);

        // Write miss does not allocate.
        do_cmd(0, 8'h06, 6'h01, 2'd1, 8'h77, 1, rd);
        do_cmd(1, 8'h06, 6'h01, 2'd1, 8'h00, 1, rd);
        chk("tp_wrmiss_fill", 32'(rd), 32'h77);

        // Reset during the second fill beat aborts the command.
        @(negedge clock);
        beats = 0;
        req = 1'b1; rw = 1'b1; index = 8'h07; tag = 6'h02; bytesel = 2'd3;
        @(negedge clock);
        req = 1'b0;
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (beats == 1) reached = 1;
            else @(negedge clock);
        end
        if (!reached) chk("rst_fill_timeout", 0, 1);
        reset = 1'b0;
        #1;
        chk("rst_fill_ctrl", 32'({mem_req, dram_we, stall, done}), 0);
        for (int i = 0; i < 256; i++) ref_valid[i] = 0;
        hit_n = 0; miss_n = 0;
        @(negedge clock);
        reset = 1'b1;
        do_cmd(1, 8'h07, 6'h02, 2'd3, 8'h00, 1, rd);
        do_cmd(1, 8'h05, 6'h01, 2'd2, 8'h00, 1, rd);

        // Randomized commands with irregular memory acks over a small aliasing address set.
        ack_mode = 1;
        for (int n = 0; n < 150; n++)
            do_cmd(1'($urandom), 8'h10 + 8'($urandom_range(0, 3)), 6'($urandom_range(0, 2)),
                   2'($urandom), 8'($urandom), 0, rd);

        // Randomized commands with ack held high so latency is exact.
        ack_mode = 0;
        for (int n = 0; n < 30; n++)
            do_cmd(1'($urandom), 8'h10 + 8'($urandom_range(0, 3)), 6'($urandom_range(0, 2)),
                   2'($urandom), 8'($urandom), 1, rd);

`ifdef CACHE_CTRL_STATS_EN
        chk("stats_hit", 32'(hit_count), 32'(hit_n));
        chk("stats_miss", 32'(miss_count), 32'(miss_n));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
